h14tx_island_sched: RTL and testbench

- Per-line period sequencer and data-island scheduler for the HDMI 1.4 TX path.
- Takes x/y from the timing generator and produces the period (video/data-island preamble, guard, active, control) for the channel encoders.
- Arbitrates up to NumSources packet sources into a variable-length data island of 1..MaxPackets packets per line, using round-robin grants.
- Drives the packet-assembler select, slot counter and per-source acknowledge.

---
 rtl/h14tx_island_sched.sv | 214 +++++++++++++++++++++
 tb/tb_h14tx_island_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/h14tx_island_sched.sv
// HDMI 1.4 TX per-line period sequencer and data-island scheduler.
// Derives the video periods from x/y and runs a small island FSM that
// round-robin grants queued packet sources into one data island per line.

package h14tx_pkg;
  typedef enum logic [2:0] {
    Control            = 3'd0,
    VideoPreamble      = 3'd1,
    VideoGuard         = 3'd2,
    VideoActive        = 3'd3,
    DataIslandPreamble = 3'd4,
    DataIslandGuard    = 3'd5,
    DataIslandActive   = 3'd6
  } period_t;
endpackage

module h14tx_island_sched
  import h14tx_pkg::*;
#(
  parameter int BitWidth     = 11,
  parameter int BitHeight    = 10,
  parameter int FrameWidth   = 1650,
  parameter int FrameHeight  = 750,
  parameter int ActiveWidth  = 1280,
  parameter int ActiveHeight = 720,
  parameter int NumSources   = 2,
  parameter int MaxPackets   = 2,
  parameter int IslandOffset = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [BitWidth-1:0]                                x,
  input  logic [BitHeight-1:0]                               y,
  input  logic [NumSources-1:0]                              req,
  output logic [NumSources-1:0]                              ack,
  output logic [((NumSources > 1) ? $clog2(NumSources) : 1)-1:0] sel,
  output logic [4:0]                                         counter,
  output period_t                                            period
);

  localparam int SelW = (NumSources > 1) ? $clog2(NumSources) : 1;
  localparam int PktW = (MaxPackets > 1) ? $clog2(MaxPackets) : 1;
  localparam int NumW = $clog2(MaxPackets + 1);
  localparam int XW   = BitWidth + 1;
  localparam int YW   = BitHeight + 1;
  localparam int S    = ActiveWidth + IslandOffset;

  localparam logic [XW-1:0] XDecision = XW'(S - 1);
  localparam logic [XW-1:0] XActEnd   = XW'(ActiveWidth);
  localparam logic [XW-1:0] XVpreLo   = XW'(FrameWidth - 10);
  localparam logic [XW-1:0] XVpreHi   = XW'(FrameWidth - 3);
  localparam logic [XW-1:0] XVgdLo    = XW'(FrameWidth - 2);
  localparam logic [XW-1:0] XVgdHi    = XW'(FrameWidth - 1);
  localparam logic [YW-1:0] YActEnd   = YW'(ActiveHeight);
  localparam logic [YW-1:0] YLast     = YW'(FrameHeight - 1);

  // The longest island must finish before the next video preamble.
  if (S + 12 + 32 * MaxPackets + 12 > FrameWidth - 10) begin : g_bad_geometry
    $fatal(1, "h14tx_island_sched: island does not fit in horizontal blanking");
  end
  if (NumSources < 1 || NumSources > 8) begin : g_bad_sources
    $fatal(1, "h14tx_island_sched: NumSources must be 1..8");
  end
  if (MaxPackets < 1 || MaxPackets > 18) begin : g_bad_packets
    $fatal(1, "h14tx_island_sched: MaxPackets must be 1..18");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    LGUARD = 3'd2,
    ACTIVE = 3'd3,
    TGUARD = 3'd4
  } island_state_t;

  island_state_t   state_r;
  logic [4:0]      cyc_r;
  logic [PktW-1:0] pkt_r;
  logic [NumW-1:0] num_r;
  logic [SelW-1:0] ptr_r;
  logic [SelW-1:0] grant_list_r [MaxPackets];

  logic [XW-1:0]   x_ext_s;
  logic [YW-1:0]   y_ext_s;
  logic [YW-1:0]   y_next_s;
  period_t         video_period_s;
  logic [SelW-1:0] gnt_list_s [MaxPackets];
  logic [NumW-1:0] gnt_num_s;
  logic [SelW-1:0] ptr_next_s;
  logic [NumSources-1:0] ack_vec_s;

  // Video period for the sampled position, widened to avoid wrap at line end.
  always_comb begin
    x_ext_s  = {1'b0, x};
    y_ext_s  = {1'b0, y};
    y_next_s = (y_ext_s == YLast) ? '0 : y_ext_s + YW'(1);
    if (x_ext_s < XActEnd && y_ext_s < YActEnd) begin
      video_period_s = VideoActive;
    end else if (y_next_s < YActEnd && x_ext_s >= XVpreLo && x_ext_s <= XVpreHi) begin
      video_period_s = VideoPreamble;
    end else if (y_next_s < YActEnd && x_ext_s >= XVgdLo && x_ext_s <= XVgdHi) begin
      video_period_s = VideoGuard;
    end else begin
      video_period_s = Control;
    end
  end

  // Round-robin grant list: walk sources from the pointer, take up to MaxPackets.
  always_comb begin : grant_calc
    int cnt;
    int idx;
    int last;
    cnt        = 0;
    last       = int'(ptr_r);
    gnt_list_s = '{default: '0};
    for (int j = 0; j < NumSources; j++) begin
      idx = int'(ptr_r) + j;
      idx = (idx >= NumSources) ? (idx - NumSources) : idx;
      if (req[SelW'(idx)] && cnt < MaxPackets) begin
        gnt_list_s[PktW'(cnt)] = SelW'(idx);
        cnt                    = cnt + 1;
        last                   = idx;
      end else begin
        cnt = cnt;
      end
    end
    gnt_num_s  = NumW'(cnt);
    ptr_next_s = (last == NumSources - 1) ? '0 : SelW'(last + 1);
  end

  // One-hot acknowledge for the source owning the current packet slot.
  always_comb begin
    ack_vec_s                      = '0;
    ack_vec_s[grant_list_r[pkt_r]] = 1'b1;
  end

  // Island FSM and registered period/slot outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cyc_r        <= 5'd0;
      pkt_r        <= '0;
      num_r        <= '0;
      ptr_r        <= '0;
      grant_list_r <= '{default: '0};
      period       <= Control;
      ack          <= '0;
      sel          <= '0;
      counter      <= 5'd0;
    end else begin
      period  <= video_period_s;
      ack     <= '0;
      counter <= 5'd0;
      case (state_r)
        IDLE: begin
          if (x_ext_s == XDecision && |req) begin
            grant_list_r <= gnt_list_s;
            num_r        <= gnt_num_s;
            ptr_r        <= ptr_next_s;
            cyc_r        <= 5'd0;
            state_r      <= PRE;
          end
        end
        PRE: begin
          period <= DataIslandPreamble;
          if (cyc_r == 5'd7) begin
            cyc_r   <= 5'd0;
            state_r <= LGUARD;
          end else begin
            cyc_r <= cyc_r + 5'd1;
          end
        end
        LGUARD: begin
          period <= DataIslandGuard;
          if (cyc_r == 5'd1) begin
            cyc_r   <= 5'd0;
            pkt_r   <= '0;
            state_r <= ACTIVE;
          end else begin
            cyc_r <= cyc_r + 5'd1;
          end
        end
        ACTIVE: begin
          period  <= DataIslandActive;
          counter <= cyc_r;
          sel     <= grant_list_r[pkt_r];
          cyc_r   <= cyc_r + 5'd1;
          if (cyc_r == 5'd31) begin
            ack <= ack_vec_s;
            if ((NumW'(pkt_r) + NumW'(1)) == num_r) begin
              cyc_r   <= 5'd0;
              state_r <= TGUARD;
            end else begin
              pkt_r <= pkt_r + PktW'(1);
            end
          end
        end
        TGUARD: begin
          period <= DataIslandGuard;
          if (cyc_r == 5'd1) begin
            cyc_r   <= 5'd0;
            state_r <= IDLE;
          end else begin
            cyc_r <= cyc_r + 5'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h14tx_island_sched.sv
// Directed self-checking bench for h14tx_island_sched (720p timing).
// Two instances share stimulus: the default one (MaxPackets=2) and one
// with MaxPackets=1 to observe round-robin rotation across lines.

module tb_h14tx_island_sched;
  import h14tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x;
  logic [9:0]  y;
  logic [1:0]  req;

  logic [1:0]  ack,  ack1;
  logic        sel,  sel1;
  logic [4:0]  counter, counter1;
  period_t     period, period1;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_sel;
  logic exp_sel1;

  h14tx_island_sched dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .req(req),
    .ack(ack), .sel(sel), .counter(counter), .period(period)
  );

  h14tx_island_sched #(.MaxPackets(1)) dut1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .req(req),
    .ack(ack1), .sel(sel1), .counter(counter1), .period(period1)
  );

  always #5 clk = ~clk;

  // Present one x/y sample and wait until the registered response is visible.
  task automatic step(input int xv, input int yv);
    x = xv[10:0];
    y = yv[9:0];
    @(posedge clk);
    #1;
  endtask

  // Expected period for a sampled position; n = packets in this line's island.
  function automatic period_t exp_period(input int xv, input int yv, input int n);
    int nxt;
    if (n > 0 && xv >= 1284 && xv <= 1291) return DataIslandPreamble;
    if (n > 0 && xv >= 1292 && xv <= 1293) return DataIslandGuard;
    if (n > 0 && xv >= 1294 && xv < 1294 + 32 * n) return DataIslandActive;
    if (n > 0 && xv >= 1294 + 32 * n && xv < 1296 + 32 * n) return DataIslandGuard;
    if (xv < 1280 && yv < 720) return VideoActive;
    nxt = (yv == 749) ? 0 : yv + 1;
    if (nxt < 720 && xv >= 1640 && xv <= 1647) return VideoPreamble;
    if (nxt < 720 && xv >= 1648 && xv <= 1649) return VideoGuard;
    return Control;
  endfunction

  // Run a full line. dut island: n packets from s0,s1; dut1 island: one packet from d1src (-1 = none).
  task automatic run_line(input int yv, input int n, input int s0, input int s1, input int d1src);
    int        off;
    int        n1;
    int        acks;
    int        acks1;
    period_t   ep;
    logic [4:0] ecnt;
    logic [1:0] eack;
    n1    = (d1src >= 0) ? 1 : 0;
    acks  = 0;
    acks1 = 0;
    for (int xv = 0; xv < 1650; xv++) begin
      step(xv, yv);
      off = xv - 1294;
      // default instance
      ep = exp_period(xv, yv, n);
      ecnt = 5'd0;
      eack = 2'b00;
      if (n > 0 && off >= 0 && off < 32 * n) begin
        exp_sel = (off < 32) ? s0[0] : s1[0];
        ecnt    = 5'(off % 32);
        eack    = (ecnt == 5'd31) ? (2'b01 << exp_sel) : 2'b00;
      end
      n_checks += 4;
      if (period !== ep) begin
        n_fail++;
        $display("FAIL period y=%0d x=%0d: got %0d expected %0d", yv, xv, period, ep);
      end
      if (counter !== ecnt) begin
        n_fail++;
        $display("FAIL counter y=%0d x=%0d: got %0d expected %0d", yv, xv, counter, ecnt);
      end
      if (sel !== exp_sel) begin
        n_fail++;
        $display("FAIL sel y=%0d x=%0d: got %0d expected %0d", yv, xv, sel, exp_sel);
      end
      if (ack !== eack) begin
        n_fail++;
        $display("FAIL ack y=%0d x=%0d: got %b expected %b", yv, xv, ack, eack);
      end
      if (ack != 2'b00) acks++;
      // single-packet instance
      ep = exp_period(xv, yv, n1);
      ecnt = 5'd0;
      eack = 2'b00;
      if (n1 > 0 && off >= 0 && off < 32) begin
        exp_sel1 = d1src[0];
        ecnt     = 5'(off);
        eack     = (ecnt == 5'd31) ? (2'b01 << exp_sel1) : 2'b00;
      end
      n_checks += 4;
      if (period1 !== ep) begin
        n_fail++;
        $display("FAIL period1 y=%0d x=%0d: got %0d expected %0d", yv, xv, period1, ep);
      end
      if (counter1 !== ecnt) begin
        n_fail++;
        $display("FAIL counter1 y=%0d x=%0d: got %0d expected %0d", yv, xv, counter1, ecnt);
      end
      if (sel1 !== exp_sel1) begin
        n_fail++;
        $display("FAIL sel1 y=%0d x=%0d: got %0d expected %0d", yv, xv, sel1, exp_sel1);
      end
      if (ack1 !== eack) begin
        n_fail++;
        $display("FAIL ack1 y=%0d x=%0d: got %b expected %b", yv, xv, ack1, eack);
      end
      if (ack1 != 2'b00) acks1++;
    end
    n_checks += 2;
    if (acks !== n) begin
      n_fail++;
      $display("FAIL ack_count y=%0d: got %0d expected %0d", yv, acks, n);
    end
    if (acks1 !== n1) begin
      n_fail++;
      $display("FAIL ack1_count y=%0d: got %0d expected %0d", yv, acks1, n1);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0);
    rst      = 1'b0;
    exp_sel  = 1'b0;
    exp_sel1 = 1'b0;
  endtask

  task automatic test_reset();
    req = 2'b00;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0);
    n_checks += 6;
    if (period !== Control) begin n_fail++; $display("FAIL reset_period: got %0d expected %0d", period, Control); end
    if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", ack); end
    if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    if (counter !== 5'd0) begin n_fail++; $display("FAIL reset_counter: got %0d expected 0", counter); end
    if (period1 !== Control) begin n_fail++; $display("FAIL reset_period1: got %0d expected %0d", period1, Control); end
    if (ack1 !== 2'b00) begin n_fail++; $display("FAIL reset_ack1: got %b expected 00", ack1); end
    rst      = 1'b0;
    exp_sel  = 1'b0;
    exp_sel1 = 1'b0;
  endtask

  task automatic test_video_line();
    req = 2'b00;
    run_line(10, 0, 0, 0, -1);
  endtask

  // Pointers at 0: dut grants 0 then 1; dut1 grants 0.
  task automatic test_two_packets();
    req = 2'b11;
    run_line(10, 2, 0, 1, 0);
  endtask

  // Only source 0 requests: both instances grant source 0 alone.
  task automatic test_single_packet();
    req = 2'b01;
    run_line(11, 1, 0, 0, 0);
  endtask

  // dut1 rotates 0,1,0 with both sources held; dut always takes both.
  task automatic test_mp1_rotation();
    req = 2'b00;
    apply_reset();
    req = 2'b11;
    run_line(20, 2, 0, 1, 0);
    run_line(21, 2, 0, 1, 1);
    run_line(22, 2, 0, 1, 0);
  endtask

  task automatic test_vertical();
    req = 2'b00;
    run_line(719, 0, 0, 0, -1);
    run_line(720, 0, 0, 0, -1);
    run_line(748, 0, 0, 0, -1);
    run_line(749, 0, 0, 0, -1);
    run_line(0,   0, 0, 0, -1);
  endtask

  // Reset in the middle of an island; dut1 pointer sits at 1 beforehand.
  task automatic test_reset_mid_island();
    req = 2'b11;
    for (int xv = 0; xv < 1300; xv++) step(xv, 10);
    rst = 1'b1;
    step(1300, 10);
    rst      = 1'b0;
    exp_sel  = 1'b0;
    exp_sel1 = 1'b0;
    n_checks += 6;
    if (period !== Control) begin n_fail++; $display("FAIL midrst_period: got %0d expected %0d", period, Control); end
    if (counter !== 5'd0) begin n_fail++; $display("FAIL midrst_counter: got %0d expected 0", counter); end
    if (ack !== 2'b00) begin n_fail++; $display("FAIL midrst_ack: got %b expected 00", ack); end
    if (sel !== 1'b0) begin n_fail++; $display("FAIL midrst_sel: got %0d expected 0", sel); end
    if (period1 !== Control) begin n_fail++; $display("FAIL midrst_period1: got %0d expected %0d", period1, Control); end
    if (sel1 !== 1'b0) begin n_fail++; $display("FAIL midrst_sel1: got %0d expected 0", sel1); end
    for (int xv = 1301; xv < 1650; xv++) begin
      step(xv, 10);
      n_checks += 3;
      if (period !== exp_period(xv, 10, 0)) begin
        n_fail++;
        $display("FAIL postrst_period x=%0d: got %0d expected %0d", xv, period, exp_period(xv, 10, 0));
      end
      if (ack !== 2'b00) begin n_fail++; $display("FAIL postrst_ack x=%0d: got %b expected 00", xv, ack); end
      if (ack1 !== 2'b00) begin n_fail++; $display("FAIL postrst_ack1 x=%0d: got %b expected 00", xv, ack1); end
    end
    // Pointer was cleared, so dut1 grants source 0 again.
    run_line(11, 2, 0, 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    x   = '0;
    y   = '0;
    req = 2'b00;
    test_reset();
    test_video_line();
    test_two_packets();
    test_single_packet();
    test_mp1_rotation();
    test_vertical();
    test_reset_mid_island();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
